// File: rtl/id_stage.sv
// Instruction decode stage: field extraction, operand forwarding, load-use
// hazard detection and the ID/EX output register.
module id_stage #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_en_i,
    input  logic [WORD_W-1:0]     if_pc_i,
    input  logic [31:0]           if_insn_i,
    output logic [REG_ADDR_W-1:0] gpr_rd_addr_0_o,
    output logic [REG_ADDR_W-1:0] gpr_rd_addr_1_o,
    input  logic [WORD_W-1:0]     gpr_rd_data_0_i,
    input  logic [WORD_W-1:0]     gpr_rd_data_1_i,
    input  logic                  ex_fwd_en_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] ex_fwd_addr_i,
    input  logic [WORD_W-1:0]     ex_fwd_data_i,
    input  logic                  mem_fwd_en_i,
    input  logic [REG_ADDR_W-1:0] mem_fwd_addr_i,
    input  logic [WORD_W-1:0]     mem_fwd_data_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  ld_hazard_o,
    output logic                  id_en_o,
    output logic [WORD_W-1:0]     id_pc_o,
    output logic [5:0]            id_op_o,
    output logic [WORD_W-1:0]     id_src_a_o,
    output logic [WORD_W-1:0]     id_src_b_o,
    output logic [WORD_W-1:0]     id_st_data_o,
    output logic [REG_ADDR_W-1:0] id_dst_addr_o,
    output logic                  id_gpr_we_
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_ALU_R = 6'h00;
    localparam logic [OP_W-1:0] OP_ALU_I = 6'h01;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'h02;
    localparam logic [OP_W-1:0] OP_STORE = 6'h03;

    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] rc;
    logic [IMM_W-1:0]      imm;
    logic [WORD_W-1:0]     imm_sext;
    logic [WORD_W-1:0]     ra_val;
    logic [WORD_W-1:0]     rb_val;

    logic                  use_a;
    logic                  use_b;
    logic [WORD_W-1:0]     dec_src_a;
    logic [WORD_W-1:0]     dec_src_b;
    logic [WORD_W-1:0]     dec_st_data;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic                  dec_we_;

    assign op       = if_insn_i[31:26];
    assign ra       = REG_ADDR_W'(if_insn_i[25:21]);
    assign rb       = REG_ADDR_W'(if_insn_i[20:16]);
    assign rc       = REG_ADDR_W'(if_insn_i[15:11]);
    assign imm      = if_insn_i[15:0];
    assign imm_sext = {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};

    assign gpr_rd_addr_0_o = ra;
    assign gpr_rd_addr_1_o = rb;

    // EX result is youngest and wins; a load in EX has no data yet.
    assign ra_val = (ex_fwd_en_i && !ex_load_i && ex_fwd_addr_i == ra) ? ex_fwd_data_i :
                    (mem_fwd_en_i && mem_fwd_addr_i == ra)              ? mem_fwd_data_i :
                                                                          gpr_rd_data_0_i;
    assign rb_val = (ex_fwd_en_i && !ex_load_i && ex_fwd_addr_i == rb) ? ex_fwd_data_i :
                    (mem_fwd_en_i && mem_fwd_addr_i == rb)              ? mem_fwd_data_i :
                                                                          gpr_rd_data_1_i;

    // Opcode decode
    always_comb begin
        use_a       = 1'b0;
        use_b       = 1'b0;
        dec_src_a   = '0;
        dec_src_b   = '0;
        dec_st_data = '0;
        dec_dst     = '0;
        dec_we_     = 1'b1;
        case (op)
            OP_ALU_R: begin
                use_a     = 1'b1;
                use_b     = 1'b1;
                dec_src_a = ra_val;
                dec_src_b = rb_val;
                dec_dst   = rc;
                dec_we_   = 1'b0;
            end
            OP_ALU_I, OP_LOAD: begin
                use_a     = 1'b1;
                dec_src_a = ra_val;
                dec_src_b = imm_sext;
                dec_dst   = rb;
                dec_we_   = 1'b0;
            end
            OP_STORE: begin
                use_a       = 1'b1;
                use_b       = 1'b1;
                dec_src_a   = ra_val;
                dec_src_b   = imm_sext;
                dec_st_data = rb_val;
            end
            default: ;
        endcase
    end

    assign ld_hazard_o = if_en_i && ex_fwd_en_i && ex_load_i && !flush_i &&
                         ((use_a && ex_fwd_addr_i == ra) || (use_b && ex_fwd_addr_i == rb));

    // ID/EX register: reset > flush > stall > load-use bubble > load
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_en_o       <= 1'b0;
            id_gpr_we_    <= 1'b1;
            id_pc_o       <= '0;
            id_op_o       <= '0;
            id_src_a_o    <= '0;
            id_src_b_o    <= '0;
            id_st_data_o  <= '0;
            id_dst_addr_o <= '0;
        end else if (flush_i) begin
            id_en_o    <= 1'b0;
            id_gpr_we_ <= 1'b1;
        end else if (!stall_i) begin
            if (ld_hazard_o) begin
                id_en_o    <= 1'b0;
                id_gpr_we_ <= 1'b1;
            end else begin
                id_en_o       <= if_en_i;
                id_gpr_we_    <= if_en_i ? dec_we_ : 1'b1;
                id_pc_o       <= if_pc_i;
                id_op_o       <= op;
                id_src_a_o    <= dec_src_a;
                id_src_b_o    <= dec_src_b;
                id_st_data_o  <= dec_st_data;
                id_dst_addr_o <= dec_dst;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes hand-computed expectations,
// monitor pops one per clock and compares the registered outputs.
module tb_id_stage;

    typedef struct {
        bit          full;
        logic        en;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [4:0]  dst;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_en_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_insn_i;
    logic [4:0]  gpr_rd_addr_0_o, gpr_rd_addr_1_o;
    logic [31:0] gpr_rd_data_0_i, gpr_rd_data_1_i;
    logic        ex_fwd_en_i, ex_load_i;
    logic [4:0]  ex_fwd_addr_i;
    logic [31:0] ex_fwd_data_i;
    logic        mem_fwd_en_i;
    logic [4:0]  mem_fwd_addr_i;
    logic [31:0] mem_fwd_data_i;
    logic        stall_i, flush_i;
    logic        ld_hazard_o;
    logic        id_en_o;
    logic [31:0] id_pc_o;
    logic [5:0]  id_op_o;
    logic [31:0] id_src_a_o, id_src_b_o, id_st_data_o;
    logic [4:0]  id_dst_addr_o;
    logic        id_gpr_we_;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    id_stage #(.WORD_W(32), .REG_ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_en_i         (if_en_i),
        .if_pc_i         (if_pc_i),
        .if_insn_i       (if_insn_i),
        .gpr_rd_addr_0_o (gpr_rd_addr_0_o),
        .gpr_rd_addr_1_o (gpr_rd_addr_1_o),
        .gpr_rd_data_0_i (gpr_rd_data_0_i),
        .gpr_rd_data_1_i (gpr_rd_data_1_i),
        .ex_fwd_en_i     (ex_fwd_en_i),
        .ex_load_i       (ex_load_i),
        .ex_fwd_addr_i   (ex_fwd_addr_i),
        .ex_fwd_data_i   (ex_fwd_data_i),
        .mem_fwd_en_i    (mem_fwd_en_i),
        .mem_fwd_addr_i  (mem_fwd_addr_i),
        .mem_fwd_data_i  (mem_fwd_data_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .ld_hazard_o     (ld_hazard_o),
        .id_en_o         (id_en_o),
        .id_pc_o         (id_pc_o),
        .id_op_o         (id_op_o),
        .id_src_a_o      (id_src_a_o),
        .id_src_b_o      (id_src_b_o),
        .id_st_data_o    (id_st_data_o),
        .id_dst_addr_o   (id_dst_addr_o),
        .id_gpr_we_      (id_gpr_we_)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] lo);
        return {op, a, b, lo};
    endfunction

    function automatic exp_t rec(input bit full, input logic en, input logic [31:0] pc,
                                 input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] st, input logic [4:0] dst, input logic we);
        exp_t e;
        e.full = full; e.en = en; e.pc = pc; e.op = op;
        e.a = a; e.b = b; e.st = st; e.dst = dst; e.we = we;
        return e;
    endfunction

    task automatic quiet();
        reset = 1'b1; if_en_i = 1'b0; if_pc_i = '0; if_insn_i = '0;
        gpr_rd_data_0_i = '0; gpr_rd_data_1_i = '0;
        ex_fwd_en_i = 1'b0; ex_load_i = 1'b0; ex_fwd_addr_i = '0; ex_fwd_data_i = '0;
        mem_fwd_en_i = 1'b0; mem_fwd_addr_i = '0; mem_fwd_data_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    // Inputs already set: check combinational hazard, queue expectation, advance a clock.
    task automatic cyc(input string name, input logic exp_haz, input exp_t e);
        #1;
        checks++;
        if (ld_hazard_o !== exp_haz) begin
            failures++;
            $display("FAIL %s ld_hazard: got %0b want %0b", name, ld_hazard_o, exp_haz);
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_addr(input string name, input logic [4:0] a0, input logic [4:0] a1);
        #1;
        checks++;
        if (gpr_rd_addr_0_o !== a0 || gpr_rd_addr_1_o !== a1) begin
            failures++;
            $display("FAIL %s rd_addr: got %0d,%0d want %0d,%0d", name,
                     gpr_rd_addr_0_o, gpr_rd_addr_1_o, a0, a1);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 1 time unit after the edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                bad = (id_en_o !== e.en) || (id_gpr_we_ !== e.we);
                if (e.full)
                    bad = bad || (id_pc_o !== e.pc) || (id_op_o !== e.op) ||
                          (id_src_a_o !== e.a) || (id_src_b_o !== e.b) ||
                          (id_st_data_o !== e.st) || (id_dst_addr_o !== e.dst);
                if (bad) begin
                    failures++;
                    $display("FAIL id_out @%0t: got en=%0b pc=%h op=%h a=%h b=%h st=%h dst=%0d we_=%0b want en=%0b pc=%h op=%h a=%h b=%h st=%h dst=%0d we_=%0b full=%0b",
                             $time, id_en_o, id_pc_o, id_op_o, id_src_a_o, id_src_b_o,
                             id_st_data_o, id_dst_addr_o, id_gpr_we_,
                             e.en, e.pc, e.op, e.a, e.b, e.st, e.dst, e.we, e.full);
                end
            end
        end
    end

    initial begin
        exp_t rst_e, bub, x;
        rst_e = rec(1, 0, 0, 0, 0, 0, 0, 0, 1);
        bub   = rec(0, 0, 0, 0, 0, 0, 0, 0, 1);

        quiet();
        reset = 1'b0;
        cyc("reset0", 0, rst_e);
        cyc("reset1", 0, rst_e);

        // ALU reg, no forwarding
        quiet(); if_en_i = 1; if_pc_i = 32'h100; if_insn_i = mk(6'h00, 1, 2, 16'h1800);
        gpr_rd_data_0_i = 5; gpr_rd_data_1_i = 7;
        chk_addr("alu_r", 1, 2);
        cyc("alu_r", 0, rec(1, 1, 32'h100, 6'h00, 5, 7, 0, 3, 0));

        // EX and MEM both on r1: EX wins
        if_pc_i = 32'h104; ex_fwd_en_i = 1; ex_fwd_addr_i = 1; ex_fwd_data_i = 32'h11;
        mem_fwd_en_i = 1; mem_fwd_addr_i = 1; mem_fwd_data_i = 32'h22;
        cyc("fwd_ex_mem", 0, rec(1, 1, 32'h104, 6'h00, 32'h11, 7, 0, 3, 0));
        mem_fwd_addr_i = 2; mem_fwd_data_i = 32'h33;
        cyc("fwd_ex_a_mem_b", 0, rec(1, 1, 32'h104, 6'h00, 32'h11, 32'h33, 0, 3, 0));

        // Load-use on ra, then MEM forward + sign-extended imm
        quiet(); if_en_i = 1; if_pc_i = 32'h108; if_insn_i = mk(6'h01, 4, 6, 16'h8000);
        gpr_rd_data_0_i = 32'hAAAA; ex_fwd_en_i = 1; ex_load_i = 1; ex_fwd_addr_i = 4;
        ex_fwd_data_i = 32'hDEAD;
        cyc("ldhaz_imm", 1, bub);
        ex_fwd_en_i = 0; ex_load_i = 0; mem_fwd_en_i = 1; mem_fwd_addr_i = 4;
        mem_fwd_data_i = 32'h99;
        cyc("imm_memfwd", 0, rec(1, 1, 32'h108, 6'h01, 32'h99, 32'hFFFF8000, 0, 6, 0));

        // Store uses rb: hazard; ALU imm ignores rb: no hazard
        quiet(); if_en_i = 1; if_pc_i = 32'h10C; if_insn_i = mk(6'h03, 1, 2, 16'h0010);
        gpr_rd_data_0_i = 5; gpr_rd_data_1_i = 7;
        ex_fwd_en_i = 1; ex_load_i = 1; ex_fwd_addr_i = 2;
        cyc("ldhaz_store_rb", 1, bub);
        if_insn_i = mk(6'h01, 1, 2, 16'h0010);
        cyc("nohaz_imm_rb", 0, rec(1, 1, 32'h10C, 6'h01, 5, 32'h10, 0, 2, 0));

        // Store, negative offset, no forwarding
        quiet(); if_en_i = 1; if_pc_i = 32'h110; if_insn_i = mk(6'h03, 1, 2, 16'hFFFC);
        gpr_rd_data_0_i = 5; gpr_rd_data_1_i = 7;
        cyc("store", 0, rec(1, 1, 32'h110, 6'h03, 5, 32'hFFFFFFFC, 7, 0, 1));

        // Unknown op: zeros, no sources so no hazard
        if_pc_i = 32'h114; if_insn_i = mk(6'h2A, 1, 2, 16'h1234);
        ex_fwd_en_i = 1; ex_load_i = 1; ex_fwd_addr_i = 1;
        cyc("other_op", 0, rec(1, 1, 32'h114, 6'h2A, 0, 0, 0, 0, 1));

        // r0 is forwarded like any register
        quiet(); if_en_i = 1; if_pc_i = 32'h118; if_insn_i = mk(6'h00, 0, 0, 16'h2800);
        gpr_rd_data_0_i = 1; gpr_rd_data_1_i = 2;
        ex_fwd_en_i = 1; ex_fwd_addr_i = 0; ex_fwd_data_i = 32'h77;
        chk_addr("r0", 0, 0);
        cyc("r0_fwd", 0, rec(1, 1, 32'h118, 6'h00, 32'h77, 32'h77, 0, 5, 0));

        // No valid instruction: no hazard, disabled output
        quiet(); if_insn_i = mk(6'h00, 1, 2, 16'h1800); ex_fwd_en_i = 1; ex_load_i = 1;
        ex_fwd_addr_i = 1;
        cyc("if_en_low", 0, bub);

        // Flush suppresses hazard and kills output
        if_en_i = 1; flush_i = 1;
        cyc("flush_haz", 0, bub);

        // Stall holds everything for three cycles, hazard still visible
        quiet(); if_en_i = 1; if_pc_i = 32'h200; if_insn_i = mk(6'h00, 1, 2, 16'h1800);
        gpr_rd_data_0_i = 5; gpr_rd_data_1_i = 7;
        x = rec(1, 1, 32'h200, 6'h00, 5, 7, 0, 3, 0);
        cyc("pre_stall", 0, x);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            if_pc_i = 32'h204 + 32'(i * 4);
            if_insn_i = mk(6'h01, 5'(i + 8), 9, 16'h0042);
            gpr_rd_data_0_i = 32'(100 + i);
            ex_fwd_en_i = (i == 1); ex_load_i = (i == 1); ex_fwd_addr_i = 5'(i + 8);
            cyc("stall_hold", (i == 1), x);
        end
        ex_fwd_en_i = 0; ex_load_i = 0; flush_i = 1;
        x.en = 0; x.we = 1;
        cyc("flush_over_stall", 0, x);

        // Reset during stall discards held instruction
        quiet(); if_en_i = 1; if_pc_i = 32'h300; if_insn_i = mk(6'h03, 3, 4, 16'h0008);
        gpr_rd_data_0_i = 32'h40; gpr_rd_data_1_i = 32'h55;
        cyc("pre_reset", 0, rec(1, 1, 32'h300, 6'h03, 32'h40, 32'h8, 32'h55, 0, 1));
        reset = 0; stall_i = 1;
        cyc("reset_in_stall", 0, rst_e);
        quiet();
        cyc("post_reset_idle", 0, bub);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, GPR address width (32 registers).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports if_en_i input 1 instruction valid; if_pc_i input WORD_W; if_insn_i input 32.
REQ-006 SHALL have ports gpr_rd_addr_0_o, gpr_rd_addr_1_o output REG_ADDR_W; gpr_rd_data_0_i, gpr_rd_data_1_i input WORD_W; these connect to the register file, whose read path already bypasses same-cycle writeback.
REQ-007 SHALL have ports ex_fwd_en_i input 1 (EX instr writes a reg), ex_load_i input 1, ex_fwd_addr_i input REG_ADDR_W, ex_fwd_data_i input WORD_W.
REQ-008 SHALL have ports mem_fwd_en_i input 1, mem_fwd_addr_i input REG_ADDR_W, mem_fwd_data_i input WORD_W.
REQ-009 SHALL have ports stall_i input 1 (downstream hold) and flush_i input 1 (pipeline kill).
REQ-010 SHALL have output ld_hazard_o 1, combinational, tells fetch to hold its instruction.
REQ-011 SHALL have registered outputs id_en_o 1, id_pc_o WORD_W, id_op_o 6, id_src_a_o WORD_W, id_src_b_o WORD_W, id_st_data_o WORD_W, id_dst_addr_o REG_ADDR_W, id_gpr_we_ 1 (active-low write enable).

Function
REQ-012 Instruction fields SHALL be op=[31:26], ra=[25:21], rb=[20:16], rc=[15:11], imm=[15:0].
REQ-013 gpr_rd_addr_0_o SHALL equal ra and gpr_rd_addr_1_o SHALL equal rb, combinationally, every cycle.
REQ-014 Operand value for ra (rb likewise) SHALL select, in priority order: ex_fwd_data_i if ex_fwd_en_i and ex_fwd_addr_i==ra and not ex_load_i; else mem_fwd_data_i if mem_fwd_en_i and mem_fwd_addr_i==ra; else gpr_rd_data_0_i.
REQ-015 Register 0 SHALL be an ordinary register (no hard-wired zero, forwarded like any other).
REQ-016 op 0x00 (ALU reg): src_a=ra val, src_b=rb val, dst=rc, we_=0; uses ra, rb.
REQ-017 op 0x01 (ALU imm) and 0x02 (LOAD): src_a=ra val, src_b=sign-extended imm, dst=rb, we_=0; uses ra only.
REQ-018 op 0x03 (STORE): src_a=ra val, src_b=sign-extended imm, st_data=rb val, we_=1; uses ra, rb.
REQ-019 Any other op: id_en_o=1, op passed through, src/st_data=0, dst=0, we_=1; uses no sources.
REQ-020 id_st_data_o SHALL be 0 for all ops except STORE.
REQ-021 ld_hazard_o SHALL be 1 when if_en_i and ex_fwd_en_i and ex_load_i and ex_fwd_addr_i matches a used source, and flush_i=0.
REQ-022 Output register update priority each edge: reset, then flush_i, then stall_i, then ld_hazard_o, then normal load.
REQ-023 flush_i=1: next cycle id_en_o=0, id_gpr_we_=1; other outputs don't-care but SHALL hold; overrides stall_i.
REQ-024 stall_i=1 (no flush): all id_* outputs SHALL hold; ld_hazard_o SHALL still be computed.
REQ-025 ld_hazard_o=1 (no stall/flush): insert bubble, id_en_o=0, id_gpr_we_=1; fetch holds so the instruction re-presents next cycle.
REQ-026 Normal: latency one cycle; id_en_o=if_en_i; when if_en_i=0, id_gpr_we_=1.
REQ-027 Simultaneous EX and MEM match on the same address SHALL take EX (youngest) data.

Reset
REQ-028 On clk edge with reset=0: id_en_o=0, id_gpr_we_=1, id_pc_o, id_op_o, id_src_a_o, id_src_b_o, id_st_data_o, id_dst_addr_o all 0.
REQ-029 Reset SHALL override flush_i and stall_i; reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-030 op0x00 ra=1 rb=2 rc=3, gpr data 5,7, no fwd -> next cycle id_en_o=1, src_a=5, src_b=7, dst=3, we_=0.
REQ-031 Same insn, ex_fwd r1=0x11, mem_fwd r1=0x22 and r2=0x33 -> src_a=0x11, src_b=0x33.
REQ-032 op0x01 ra=4, EX load dest r4 -> ld_hazard_o=1, next id_en_o=0; next cycle ex_load_i=0, mem_fwd r4=0x99 -> src_a=0x99, src_b=sign-extended imm (imm=0x8000 -> 0xFFFF8000).
REQ-033 op0x03 ra=1 rb=2, EX load dest r2 -> hazard; op0x01 with EX load dest r2 (rb unused) -> no hazard.
REQ-034 stall_i=1 for 3 cycles with changing if_insn_i -> id_* unchanged; flush_i=1 together with stall_i -> id_en_o=0 next cycle.
REQ-035 Load valid insn, then reset=0 for one cycle with stall_i=1 -> all outputs at reset values of REQ-028.
